decode_stage: RTL
=================

Name: decode_stage

Overview:
Pipelined successor to the single-cycle decode block. It accepts fetched instructions over a valid/ready handshake and decodes control, immediate and register operands. It registers everything into an ID/EX output register with its own valid/ready handshake. Adds write-first bypass on the register file, load-use stall detection, flush, an illegal-opcode flag and a parametrised register count. It sits between the fetch stage and the execute stage.

Parameters:
DATA_WIDTH, 32, width of instructions, PC, register data and immediates
REG_COUNT, 32, number of architectural registers; ADDR_W = $clog2(REG_COUNT)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  decode accepts instruction this cycle
in_instr  in  DATA_WIDTH  instruction word
in_pc  in  DATA_WIDTH  PC of in_instr
flush  in  1  kill the in-flight instruction and the output register
wb_en  in  1  writeback enable
wb_addr  in  ADDR_W  writeback register
wb_data  in  DATA_WIDTH  writeback data
out_valid  out  1  ID/EX register holds a valid instruction
out_ready  in  1  execute accepts ID/EX contents
out_alu_ctrl  out  3  ALU operation
out_alu_src  out  1  1 = immediate operand
out_mem_write  out  1  store
out_result_src  out  2  00 ALU, 01 memory, 10 PC+4
out_reg_write  out  1  instruction writes rd
out_branch  out  1  conditional branch
out_jump  out  1  jal or jalr
out_jalr  out  1  jalr
out_illegal  out  1  unsupported opcode
out_rd, out_rs1, out_rs2  out  ADDR_W each  register indices
out_rd1, out_rd2  out  DATA_WIDTH each  operand values
out_imm_ext  out  DATA_WIDTH  sign-extended immediate
out_pc  out  DATA_WIDTH  registered in_pc
a0  out  DATA_WIDTH  live value of register 10 (debug)

Behaviour:
- Reset (rst_n=0, asynchronous): all out_* = 0, including out_valid. Every register-file entry = 0. a0 = 0.
- Register-file write: on the clk edge when wb_en=1 and wb_addr!=0. x0 always reads 0. Writes proceed even during stall or flush.
- Read bypass: if wb_en=1, wb_addr==rs and rs!=0, the operand read sees wb_data in the same cycle (write-first).
- Decoding supports R, I-ALU, load, store, branch, jal, jalr, lui.
- Any other opcode sets out_illegal=1 and forces out_reg_write, out_mem_write, out_branch and out_jump to 0.
- Immediate width rules: I, S, B, J and U formats are sign-extended to DATA_WIDTH. U format fills the low 12 bits with zero.
- Load-use hazard (lu): out_valid=1 AND out_result_src==01 AND out_rd!=0 AND out_rd matches a source register the incoming instruction uses. rs2 counts only for R, store and branch.
- Handshake: adv = out_ready | ~out_valid; in_ready = adv & ~lu.
- Latency: one cycle. On an edge with adv=1, the ID/EX register loads the decode of in_instr, and out_valid <= in_valid & ~lu.
- Stall: with adv=0, all out_* hold their values.
- Load-use bubble: with lu=1 and adv=1, out_valid <= 0 and the instruction is held upstream (in_ready=0).
- Flush (highest priority): next edge out_valid <= 0. in_ready=1 so the current input is consumed and discarded. Flush combined with a simultaneous wb_en still writes the register file.
- When out_valid=0, the out_* payload values are don't-care.

Decomposition:
- Package decode_pkg:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI)
  - alu_ctrl_e enum (ADD, SUB, AND, OR, XOR, SLT, SLL, SRL)
  - imm_src_e enum (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U)
  - result_src_e enum (RES_ALU, RES_MEM, RES_PC4)
- One sub-module, regfile_bypass (parameters DATA_WIDTH and REG_COUNT): two read ports with write-first bypass, one write port, a0 tap.
- Control decode, immediate extension and hazard logic stay inline.

Test Plan:
1. Reset, then in_instr=0x00500093 (addi x1,x0,5) with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_rd=1, out_imm_ext=5, out_alu_src=1, out_reg_write=1, out_alu_ctrl=ADD.
2. wb_en=1, wb_addr=2, wb_data=0xDEAD0000 in the same cycle that 0x001101B3 (add x3,x2,x1) is presented -> out_rd1=0xDEAD0000 (bypass). A write to x0 followed by a read of x0 returns 0.
3. 0x0000A103 (lw x2,0(x1)) accepted, then 0x001101B3 presented -> one cycle with in_ready=0 and out_valid=0, then the add is accepted. Its out_rs1=2.
4. out_ready=0 for 3 cycles while out_valid=1 -> all out_* stable and in_ready=0. Releasing out_ready lets the next instruction advance.
5. flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0 and the input is dropped (in_ready=1). Instr 0x0000007F -> out_illegal=1, out_reg_write=0, out_mem_write=0.
6. rst_n deasserted mid-stall with the register file non-zero -> out_valid=0, a0=0 and all registers read 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared opcodes, control encodings and ALU-function decode for the pipelined decode stage.
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ADD = 3'd0, SUB = 3'd1, AND = 3'd2, OR  = 3'd3,
        XOR = 3'd4, SLT = 3'd5, SLL = 3'd6, SRL = 3'd7
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10
    } result_src_e;

    // Unsigned compares share SLT and arithmetic shifts share SRL in this ALU.
    function automatic alu_ctrl_e alu_decode(input logic [2:0] funct3, input logic sub_sel);
        alu_ctrl_e res;
        case (funct3)
            3'b000:  res = sub_sel ? SUB : ADD;
            3'b001:  res = SLL;
            3'b010:  res = SLT;
            3'b011:  res = SLT;
            3'b100:  res = XOR;
            3'b101:  res = SRL;
            3'b110:  res = OR;
            3'b111:  res = AND;
            default: res = ADD;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/decode_stage_regfile_bypass.sv
// Register file with write-first read bypass on both read ports and a live x10 debug tap.
module regfile_bypass #(
    parameter int  DATA_WIDTH = 32,
    parameter int  REG_COUNT  = 32,
    localparam int ADDR_W     = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wb_en,
    input  logic [ADDR_W-1:0]     i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic [ADDR_W-1:0]     i_rs1,
    input  logic [ADDR_W-1:0]     i_rs2,
    output logic [DATA_WIDTH-1:0] o_rd1,
    output logic [DATA_WIDTH-1:0] o_rd2,
    output logic [DATA_WIDTH-1:0] o_a0
);

    logic [DATA_WIDTH-1:0] r_regs [REG_COUNT];

    // Register storage; x0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_addr != '0)) begin
            r_regs[i_wb_addr] <= i_wb_data;
        end
    end

    // Read ports see a same-cycle writeback before the stored value.
    always_comb begin
        o_rd1 = '0;
        o_rd2 = '0;
        if (i_rs1 == '0) begin
            o_rd1 = '0;
        end else if (i_wb_en && (i_wb_addr == i_rs1)) begin
            o_rd1 = i_wb_data;
        end else begin
            o_rd1 = r_regs[i_rs1];
        end
        if (i_rs2 == '0) begin
            o_rd2 = '0;
        end else if (i_wb_en && (i_wb_addr == i_rs2)) begin
            o_rd2 = i_wb_data;
        end else begin
            o_rd2 = r_regs[i_rs2];
        end
    end

    if (REG_COUNT > 10) begin : g_a0
        assign o_a0 = r_regs[10];
    end else begin : g_no_a0
        assign o_a0 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// Pipelined decode: operand read with bypass, control/immediate decode, load-use stall
// and flush, registered into a handshaked ID/EX register.
module decode_stage
    import decode_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  REG_COUNT  = 32,
    localparam int ADDR_W     = $clog2(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic                  flush,
    input  logic                  wb_en,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2:0]            out_alu_ctrl,
    output logic                  out_alu_src,
    output logic                  out_mem_write,
    output logic [1:0]            out_result_src,
    output logic                  out_reg_write,
    output logic                  out_branch,
    output logic                  out_jump,
    output logic                  out_jalr,
    output logic                  out_illegal,
    output logic [ADDR_W-1:0]     out_rd,
    output logic [ADDR_W-1:0]     out_rs1,
    output logic [ADDR_W-1:0]     out_rs2,
    output logic [DATA_WIDTH-1:0] out_rd1,
    output logic [DATA_WIDTH-1:0] out_rd2,
    output logic [DATA_WIDTH-1:0] out_imm_ext,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] a0
);

    typedef struct packed {
        logic [2:0]            alu_ctrl;
        logic                  alu_src;
        logic                  mem_write;
        logic [1:0]            result_src;
        logic                  reg_write;
        logic                  branch;
        logic                  jump;
        logic                  jalr;
        logic                  illegal;
        logic [ADDR_W-1:0]     rd;
        logic [ADDR_W-1:0]     rs1;
        logic [ADDR_W-1:0]     rs2;
        logic [DATA_WIDTH-1:0] rd1;
        logic [DATA_WIDTH-1:0] rd2;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [DATA_WIDTH-1:0] pc;
    } idex_t;

    logic [6:0]            w_opcode;
    logic [ADDR_W-1:0]     w_rs1;
    logic [ADDR_W-1:0]     w_rs2;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;
    logic [31:0]           w_imm32;
    imm_src_e              w_imm_src;
    logic                  w_use_rs1;
    logic                  w_use_rs2;
    logic                  w_lu;
    logic                  w_adv;
    idex_t                 w_idex;
    idex_t                 r_idex;
    logic                  r_valid;

    assign w_opcode = in_instr[6:0];
    assign w_rs1    = ADDR_W'(in_instr[19:15]);
    assign w_rs2    = ADDR_W'(in_instr[24:20]);

    regfile_bypass #(.DATA_WIDTH(DATA_WIDTH), .REG_COUNT(REG_COUNT)) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_wb_en   (wb_en),
        .i_wb_addr (wb_addr),
        .i_wb_data (wb_data),
        .i_rs1     (w_rs1),
        .i_rs2     (w_rs2),
        .o_rd1     (w_rd1),
        .o_rd2     (w_rd2),
        .o_a0      (a0)
    );

    // Control decode; unknown opcodes become a side-effect-free illegal marker.
    always_comb begin
        w_idex            = '0;
        w_imm_src         = IMM_I;
        w_use_rs1         = 1'b0;
        w_use_rs2         = 1'b0;
        w_idex.alu_ctrl   = ADD;
        w_idex.result_src = RES_ALU;
        case (w_opcode)
            OP_R: begin
                w_idex.alu_ctrl  = alu_decode(in_instr[14:12], in_instr[30]);
                w_idex.reg_write = 1'b1;
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
            end
            OP_I: begin
                w_idex.alu_ctrl  = alu_decode(in_instr[14:12], 1'b0);
                w_idex.alu_src   = 1'b1;
                w_idex.reg_write = 1'b1;
                w_use_rs1        = 1'b1;
            end
            OP_LOAD: begin
                w_idex.alu_src    = 1'b1;
                w_idex.result_src = RES_MEM;
                w_idex.reg_write  = 1'b1;
                w_use_rs1         = 1'b1;
            end
            OP_STORE: begin
                w_idex.alu_src   = 1'b1;
                w_idex.mem_write = 1'b1;
                w_imm_src        = IMM_S;
                w_use_rs1        = 1'b1;
                w_use_rs2        = 1'b1;
            end
            OP_BRANCH: begin
                w_idex.alu_ctrl = SUB;
                w_idex.branch   = 1'b1;
                w_imm_src       = IMM_B;
                w_use_rs1       = 1'b1;
                w_use_rs2       = 1'b1;
            end
            OP_JAL: begin
                w_idex.jump       = 1'b1;
                w_idex.reg_write  = 1'b1;
                w_idex.result_src = RES_PC4;
                w_imm_src         = IMM_J;
            end
            OP_JALR: begin
                w_idex.jump       = 1'b1;
                w_idex.jalr       = 1'b1;
                w_idex.alu_src    = 1'b1;
                w_idex.reg_write  = 1'b1;
                w_idex.result_src = RES_PC4;
                w_use_rs1         = 1'b1;
            end
            OP_LUI: begin
                w_idex.alu_src   = 1'b1;
                w_idex.reg_write = 1'b1;
                w_imm_src        = IMM_U;
            end
            default: begin
                w_idex.illegal = 1'b1;
            end
        endcase
        w_idex.rd      = ADDR_W'(in_instr[11:7]);
        w_idex.rs1     = w_rs1;
        w_idex.rs2     = w_rs2;
        w_idex.rd1     = w_rd1;
        w_idex.rd2     = w_rd2;
        w_idex.imm_ext = DATA_WIDTH'($signed(w_imm32));
        w_idex.pc      = in_pc;
    end

    // Immediate assembly as a 32-bit signed value, widened to DATA_WIDTH above.
    always_comb begin
        w_imm32 = '0;
        case (w_imm_src)
            IMM_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            IMM_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            IMM_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            IMM_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            IMM_U:   w_imm32 = {in_instr[31:12], 12'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_lu = r_valid && (r_idex.result_src == RES_MEM) && (r_idex.rd != '0) &&
                  ((w_use_rs1 && (r_idex.rd == w_rs1)) || (w_use_rs2 && (r_idex.rd == w_rs2)));
    assign w_adv    = out_ready | ~r_valid;
    assign in_ready = flush | (w_adv & ~w_lu);

    // ID/EX register: flush kills, a stall holds, otherwise load the new decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idex  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_adv) begin
            r_valid <= in_valid & ~w_lu;
            r_idex  <= w_idex;
        end
    end

    assign out_valid      = r_valid;
    assign out_alu_ctrl   = r_idex.alu_ctrl;
    assign out_alu_src    = r_idex.alu_src;
    assign out_mem_write  = r_idex.mem_write;
    assign out_result_src = r_idex.result_src;
    assign out_reg_write  = r_idex.reg_write;
    assign out_branch     = r_idex.branch;
    assign out_jump       = r_idex.jump;
    assign out_jalr       = r_idex.jalr;
    assign out_illegal    = r_idex.illegal;
    assign out_rd         = r_idex.rd;
    assign out_rs1        = r_idex.rs1;
    assign out_rs2        = r_idex.rs2;
    assign out_rd1        = r_idex.rd1;
    assign out_rd2        = r_idex.rd2;
    assign out_imm_ext    = r_idex.imm_ext;
    assign out_pc         = r_idex.pc;

endmodule
